// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side bundle for the hazard scheduler: ID-stage instruction summary,
// EX redirect in, pipeline register controls and statistics out.
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_load;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_is_mdu;
  logic        id_reads_hilo;
  logic        ex_redirect;

  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  stall_cause;
  logic        mdu_busy;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  // Handshake: no valid/ready; every signal is a level that holds for one
  // pipeline cycle and is consumed on the falling clock edge.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_load,
           id_dest, id_reg_write, id_is_mdu, id_reads_hilo, ex_redirect,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, stall_cause, mdu_busy,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_load,
           id_dest, id_reg_write, id_is_mdu, id_reads_hilo, ex_redirect,
    output pc_we, ifid_we, ifid_flush, idex_bubble, stall_cause, mdu_busy,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for a five-stage MIPS pipeline: load-use, busy-MDU and
// EX-redirect handling, with a shadow of the EX instruction and statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned MDU_LATENCY    = 32,
  parameter logic [31:0] STALL_CNT_INIT = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_LOAD_USE = 2'b01,
    CAUSE_MDU      = 2'b10,
    CAUSE_REDIRECT = 2'b11
  } cause_e;

  localparam logic [5:0] MDU_LAT = 6'(MDU_LATENCY);

  logic        ex_valid_q, ex_valid_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic [4:0]  ex_dest_q, ex_dest_d;
  logic [5:0]  mdu_cnt_q, mdu_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic   load_use_hz;
  logic   mdu_hz;
  cause_e cause;
  logic   pc_we, ifid_we, ifid_flush, idex_bubble;

  always_comb begin
    load_use_hz = hz.id_valid && ex_valid_q && ex_is_load_q && (ex_dest_q != 5'd0) &&
                  ((hz.id_uses_rs && (hz.id_rs == ex_dest_q)) ||
                   (hz.id_uses_rt && (hz.id_rt == ex_dest_q)));
    mdu_hz      = hz.id_valid && (mdu_cnt_q != 6'd0) && (hz.id_is_mdu || hz.id_reads_hilo);
  end

  // Priority: reset, redirect, load-use, MDU busy.
  always_comb begin
    cause       = CAUSE_NONE;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hz.ex_redirect) begin
      cause       = CAUSE_REDIRECT;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use_hz || mdu_hz) begin
      cause       = load_use_hz ? CAUSE_LOAD_USE : CAUSE_MDU;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_is_load_d   = ex_is_load_q;
    ex_dest_d      = ex_dest_q;
    mdu_cnt_d      = mdu_cnt_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    if (idex_bubble) begin
      ex_valid_d   = 1'b0;
      ex_is_load_d = 1'b0;
    end else begin
      ex_valid_d   = hz.id_valid;
      ex_is_load_d = hz.id_is_load && hz.id_valid;
      ex_dest_d    = hz.id_reg_write ? hz.id_dest : 5'd0;
    end

    // A squashed or stalled MDU op never starts the unit.
    if (!idex_bubble && hz.id_valid && hz.id_is_mdu) begin
      mdu_cnt_d = MDU_LAT;
    end else if (mdu_cnt_q != 6'd0) begin
      mdu_cnt_d = mdu_cnt_q - 6'd1;
    end

    if (((cause == CAUSE_LOAD_USE) || (cause == CAUSE_MDU)) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (cause == CAUSE_REDIRECT) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  // All state moves on the falling edge, together with IF/ID and ID/EX.
  always_ff @(negedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_dest_q      <= 5'd0;
      mdu_cnt_q      <= 6'd0;
      stall_cycles_q <= STALL_CNT_INIT;
      flush_count_q  <= 16'd0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_dest_q      <= ex_dest_d;
      mdu_cnt_q      <= mdu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.pc_we        = pc_we;
  assign hz.ifid_we      = ifid_we;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.stall_cause  = cause;
  assign hz.mdu_busy     = (mdu_cnt_q != 6'd0);
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard scheduler for the five-stage MIPS pipeline. It decides each cycle whether the PC and IF/ID register advance, whether IF/ID is flushed, and whether the ID/EX register captures the decoded instruction or a bubble. It handles three cases: load-use hazards, busy multiply/divide unit (MDU) conflicts, and EX-stage redirects from branches and jumps. It sits beside the decode stage, keeps a shadow of the instruction it admitted into EX, and keeps stall and flush statistics.

## Interface
Parameters:
- MDU_LATENCY, 32, cycles the MDU is busy after an MDU op enters EX; legal range 1..63.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, the same edge as the IF/ID and ID/EX registers.
- rst  in  1  synchronous reset, active-high, sampled on the falling edge of clk.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  5 each  source register numbers.
- id_uses_rs, id_uses_rt  in  1 each  instruction reads that source.
- id_is_load  in  1  ID instruction is a load.
- id_dest  in  5  resolved destination (after RegDst/RegDt0 selection).
- id_reg_write  in  1  ID instruction writes id_dest.
- id_is_mdu  in  1  ID instruction starts the MDU (mult/div).
- id_reads_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo).
- ex_redirect  in  1  EX resolved a taken branch (Condition) or a Jump this cycle.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX captures all-zero control (NOP) instead of ID outputs.
- stall_cause  out  2  00 none, 01 load-use, 10 MDU busy, 11 redirect.
- mdu_busy  out  1  MDU counter is nonzero.
- stall_cycles  out  32  count of cycles with cause 01 or 10; saturates at 0xFFFFFFFF.
- flush_count  out  16  count of redirects; wraps modulo 2^16.

## Operation
- State:
  - ex_valid, ex_is_load, ex_dest: shadow of the instruction in EX.
  - mdu_cnt: 6 bits.
  - The two statistics counters.
- Cause evaluation is combinational, with priority rst > redirect > load-use > MDU > none.
- Redirect: applies when ex_redirect=1.
  - Outputs: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
  - The ID instruction is squashed. If it is an MDU op, it does not start the MDU.
- Load-use: applies when id_valid, ex_valid, ex_is_load, ex_dest≠0, and either (id_uses_rs and id_rs==ex_dest) or (id_uses_rt and id_rt==ex_dest).
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1.
- MDU busy: applies when id_valid, mdu_cnt≠0, and (id_is_mdu or id_reads_hilo).
  - Outputs are the same as load-use.
- None: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- Shadow update on each falling edge:
  - If idex_bubble=1: ex_valid=0 and ex_is_load=0.
  - Otherwise: ex_valid←id_valid, ex_is_load←id_is_load&id_valid, ex_dest←id_reg_write?id_dest:0.
- mdu_cnt update on each falling edge:
  - If an unbubbled id_valid&id_is_mdu instruction is admitted: mdu_cnt←MDU_LATENCY.
  - Else if mdu_cnt≠0: mdu_cnt←mdu_cnt−1. This decrement continues during redirects and stalls.
- stall_cycles increments when cause is 01 or 10. flush_count increments when cause is 11.
- id_valid=0 never produces a stall. Register 0 never produces a load-use stall.

## Timing
- While rst=1:
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, stall_cause=00.
  - On the reset edge: ex_valid=0, ex_is_load=0, ex_dest=0, mdu_cnt=0, stall_cycles=0, flush_count=0. mdu_busy=0 follows.
- The first falling edge with rst=0 operates normally.
- Reset asserted mid-MDU clears mdu_cnt on that edge.
- Load-use stall lasts exactly 1 cycle. The inserted bubble clears ex_is_load; forwarding covers the remaining distance.
- MDU stall lasts until mdu_cnt reaches 0. An MDU op issued in cycle t allows a dependent mfhi to enter EX at edge t+MDU_LATENCY+1 at the earliest.
- A redirect in the same cycle as a load-use or MDU hazard reports 11. No stall is counted for that cycle.
- Back-to-back redirects flush on every cycle.
- Output-to-input combinational paths: none. No output depends on ex_redirect through state within the same cycle except via the priority logic.

## Test plan
- Reset: hold rst for 2 edges with mdu_cnt previously at 5 -> ifid_flush=1 and idex_bubble=1 during reset; afterwards mdu_busy=0 and both counters 0.
- Load-use: lw $8, then add $9,$8,$1 in ID -> exactly one cycle with pc_we=0, idex_bubble=1, cause=01, then the add advances; stall_cycles=1. The same sequence with $0 as destination -> no stall.
- MDU: MDU_LATENCY=4, mult admitted, then mflo in ID -> cause=10 until mdu_cnt=0; mflo enters EX 5 edges after mult; stall_cycles=4.
- Redirect priority: ex_redirect=1 while the ID instruction has a load-use hazard -> cause=11, flush=1, bubble=1; flush_count=1, stall_cycles unchanged.
- Squashed MDU: mult in ID while ex_redirect=1 -> mdu_busy stays 0.
- Wrap and saturate: force 65536 redirects -> flush_count=0. Preload stall_cycles near its maximum and stall -> it holds at 0xFFFFFFFF.
